// File: rtl/dm_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the CPU32 data-memory bus.
// CPU stores fill a TX FIFO; a baud-rate state machine serialises the bytes onto tx.
module dm_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h0001_0000,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic [3:0]  width,
  input  logic        write_en,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        tx,
  output logic        irq
);

  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);
  localparam logic [BaudW-1:0] BaudLoad = BaudW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0]  CntFull  = CntW'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e            r_state, w_state_next;
  logic [PtrW-1:0]   r_wptr, r_rptr;
  logic [CntW-1:0]   r_count;
  logic [7:0]        r_mem [FIFO_DEPTH];
  logic              r_ovf, r_enable;
  logic [BaudW-1:0]  r_baud;
  logic [2:0]        r_bit;
  logic [7:0]        r_shift;
  logic [31:0]       r_data_out;

  logic              w_sel, w_acc, w_wr, w_push_req, w_push, w_pop;
  logic              w_full, w_empty, w_busy, w_baud_done;
  logic [1:0]        w_offset;
  logic [31:0]       w_reg_val;
  logic              w_unused_data;

  // Byte accesses must be word-aligned; misaligned ones are dropped entirely.
  assign w_sel       = (address[31:4] == BASE_ADDR[31:4]) && (width == 4'd1 || width == 4'd4);
  assign w_acc       = w_sel && (width == 4'd4 || address[1:0] == 2'b00);
  assign w_offset    = address[3:2];
  assign w_wr        = w_acc && write_en;
  assign w_push_req  = w_wr && (w_offset == 2'd0);
  assign w_full      = (r_count == CntFull);
  assign w_empty     = (r_count == '0);
  assign w_baud_done = (r_baud == '0);
  assign w_busy      = (r_state != StIdle);
  // Pop from IDLE, or at the last STOP cycle so back-to-back frames have no gap.
  assign w_pop       = r_enable && !w_empty &&
                       ((r_state == StIdle) || (r_state == StStop && w_baud_done));
  assign w_push      = w_push_req && (!w_full || w_pop);
  assign w_unused_data = ^data_in[31:8];

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wptr] <= data_in[7:0];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
      r_enable <= 1'b1;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_push_req && !w_push) begin
        r_ovf <= 1'b1;
      end else if (w_wr && w_offset == 2'd1 && data_in[3]) begin
        r_ovf <= 1'b0;
      end
      if (w_wr && w_offset == 2'd2) r_enable <= data_in[0];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= StIdle;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:  if (w_pop) w_state_next = StStart;
      StStart: if (w_baud_done) w_state_next = StData;
      StData:  if (w_baud_done && r_bit == 3'd7) w_state_next = StStop;
      StStop:  if (w_baud_done) w_state_next = w_pop ? StStart : StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    tx = 1'b1;
    case (r_state)
      StStart: tx = 1'b0;
      StData:  tx = r_shift[0];
      default: tx = 1'b1;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else if (w_pop) begin
      r_shift <= r_mem[r_rptr];
      r_baud  <= BaudLoad;
      r_bit   <= '0;
    end else if (w_busy) begin
      if (w_baud_done) begin
        r_baud <= BaudLoad;
        if (r_state == StData) begin
          r_shift <= {1'b0, r_shift[7:1]};
          r_bit   <= r_bit + 3'd1;
        end
      end else begin
        r_baud <= r_baud - 1'b1;
      end
    end
  end

  always_comb begin
    w_reg_val = '0;
    case (w_offset)
      2'd1:    w_reg_val = {23'd0, 5'(r_count), r_ovf, w_busy, w_empty, w_full};
      2'd2:    w_reg_val = {31'd0, r_enable};
      default: w_reg_val = '0;
    endcase
    if (width == 4'd1) w_reg_val[31:8] = '0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_data_out <= '0;
    else        r_data_out <= (w_acc && !write_en) ? w_reg_val : '0;
  end

  assign data_out = r_data_out;
  assign irq      = r_enable && w_empty && !w_busy;

endmodule

// File: tb/tb_dm_uart_tx.sv
// Bench for dm_uart_tx: a queue-based frame model checked every cycle, directed
// scenarios with literal expectations, then randomized bus traffic.
module tb_dm_uart_tx;
  localparam logic [31:0] BASE = 32'h0001_0000;
  localparam int C = 16;
  localparam int D = 8;
  localparam int FRAME = 10 * C;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] address = '0;
  logic [3:0]  width = '0;
  logic        write_en = 1'b0;
  logic [31:0] data_in = '0;
  logic [31:0] data_out;
  logic        tx, irq;

  dm_uart_tx #(.BASE_ADDR(BASE), .CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
    .clock(clock), .reset(reset), .address(address), .width(width),
    .write_en(write_en), .data_in(data_in), .data_out(data_out), .tx(tx), .irq(irq)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: FIFO as a queue, frame as a position 0..FRAME-1 within the current byte.
  logic [7:0]  q[$];
  bit          m_busy = 1'b0;
  int          m_pos = 0;
  logic [7:0]  m_cur = '0;
  bit          m_en = 1'b1;
  bit          m_ovf = 1'b0;
  logic [31:0] m_rd = '0;

  always @(posedge clock or negedge reset) begin
    int sz, off;
    bit acc, pop;
    logic [31:0] v;
    if (!reset) begin
      q.delete();
      m_busy = 1'b0; m_pos = 0; m_en = 1'b1; m_ovf = 1'b0; m_rd = '0;
    end else begin
      sz  = q.size();
      acc = (address[31:4] == BASE[31:4]) && (width == 4'd1 || width == 4'd4) &&
            (width == 4'd4 || address[1:0] == 2'b00);
      off = int'(address[3:2]);
      v = '0;
      if (acc && !write_en) begin
        if (off == 1) v = {23'd0, 5'(sz), m_ovf, m_busy, sz == 0, sz == D};
        if (off == 2) v = {31'd0, m_en};
        if (width == 4'd1) v = v & 32'hFF;
      end
      pop = m_en && sz > 0 && (!m_busy || m_pos == FRAME - 1);
      if (pop) begin
        m_cur = q.pop_front(); m_busy = 1'b1; m_pos = 0;
      end else if (m_busy) begin
        if (m_pos == FRAME - 1) m_busy = 1'b0;
        else m_pos++;
      end
      if (acc && write_en) begin
        if (off == 0) begin
          if (sz < D || pop) q.push_back(data_in[7:0]);
          else m_ovf = 1'b1;
        end
        if (off == 1 && data_in[3]) m_ovf = 1'b0;
        if (off == 2) m_en = data_in[0];
      end
      m_rd = v;
    end
  end

  function automatic logic exp_tx();
    int k;
    if (!m_busy) return 1'b1;
    k = m_pos / C;
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return m_cur[k-1];
  endfunction

  always @(negedge clock) begin
    if (chk_on) begin
      chk("tx", {31'd0, tx}, {31'd0, exp_tx()});
      chk("irq", {31'd0, irq}, {31'd0, m_en && q.size() == 0 && !m_busy});
      chk("data_out", data_out, m_rd);
    end
  end

  // Called at a negedge; the access is consumed by the next posedge, returns at the next negedge.
  task automatic op(input logic [31:0] a, input logic [3:0] w, input logic we,
                    input logic [31:0] d);
    address = a; width = w; write_en = we; data_in = d;
    @(negedge clock);
    width = '0; write_en = 1'b0;
  endtask

  initial begin
    logic [9:0] seq_a5;
    logic [9:0] fr [2];
    int errs, irq_errs, n;
    logic [3:0] w;
    seq_a5 = 10'b11_0100_1010;

    #2 reset = 1'b0;
    #1 chk_on = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    // Reset values
    chk("rst_irq", {31'd0, irq}, 32'd1);
    chk("rst_tx", {31'd0, tx}, 32'd1);
    op(BASE + 4, 4'd4, 1'b0, 0);
    chk("rst_status", data_out, 32'h0000_0002);

    // Single byte 0xA5
    op(BASE, 4'd4, 1'b1, 32'h0000_00A5);
    chk("a5_pre_tx", {31'd0, tx}, 32'd1);
    @(negedge clock);
    errs = 0; irq_errs = 0;
    for (int i = 0; i < FRAME; i++) begin
      if (tx !== seq_a5[i / C]) errs++;
      if (irq !== 1'b0) irq_errs++;
      @(negedge clock);
    end
    chk("a5_bits", errs, 0);
    chk("a5_irq_low", irq_errs, 0);
    chk("a5_end_tx", {31'd0, tx}, 32'd1);
    chk("a5_end_irq", {31'd0, irq}, 32'd1);

    // Back-to-back 0x55, 0x0F with status reads mid-frame
    fr[0] = {1'b1, 8'h55, 1'b0};
    fr[1] = {1'b1, 8'h0F, 1'b0};
    op(BASE, 4'd4, 1'b1, 32'h55);
    op(BASE, 4'd4, 1'b1, 32'h0F);
    errs = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      logic [9:0] f;
      f = fr[i / FRAME];
      if (tx !== f[(i % FRAME) / C]) errs++;
      if (i == 50 || i == 200) begin
        address = BASE + 4; width = 4'd4; write_en = 1'b0;
      end
      if (i == 51) begin
        chk("b2b_status1", data_out, 32'h0000_0014);
        width = '0;
      end
      if (i == 201) begin
        chk("b2b_status2", data_out, 32'h0000_0006);
        width = '0;
      end
      @(negedge clock);
    end
    chk("b2b_bits", errs, 0);
    chk("b2b_end_tx", {31'd0, tx}, 32'd1);

    // Overflow with the shifter disabled, then drain exactly 8 frames
    op(BASE + 8, 4'd4, 1'b1, 0);
    for (int i = 0; i < 9; i++) op(BASE, 4'd4, 1'b1, 32'(i + 8'h30));
    op(BASE + 4, 4'd4, 1'b0, 0);
    chk("ovf_status", data_out, 32'h0000_0089);
    op(BASE + 4, 4'd4, 1'b1, 32'h8);
    op(BASE + 4, 4'd4, 1'b0, 0);
    chk("ovf_cleared", data_out, 32'h0000_0081);
    op(BASE + 8, 4'd4, 1'b1, 1);
    n = 0;
    while (irq === 1'b0 && n < 5000) begin
      n++;
      @(negedge clock);
    end
    chk("drain_8_frames_cycles", n, 1 + 8 * FRAME);

    // Push on the same edge the shifter pops from a full FIFO
    op(BASE + 8, 4'd4, 1'b1, 0);
    for (int i = 0; i < 8; i++) op(BASE, 4'd4, 1'b1, 32'(i));
    op(BASE + 8, 4'd4, 1'b1, 1);
    op(BASE, 4'd1, 1'b1, 32'h99);
    op(BASE + 4, 4'd4, 1'b0, 0);
    chk("collide_status", data_out, 32'h0000_0085);

    // Asynchronous reset in the middle of the start bit
    @(posedge clock);
    #1 chk("pre_rst_tx", {31'd0, tx}, 32'd0);
    reset = 1'b0;
    #1 chk("rst_async_tx", {31'd0, tx}, 32'd1);
    chk("rst_async_dout", data_out, 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    op(BASE + 4, 4'd4, 1'b0, 0);
    chk("rst2_status", data_out, 32'h0000_0002);
    chk("rst2_irq", {31'd0, irq}, 32'd1);

    // Bus compliance
    op(BASE + 5, 4'd1, 1'b0, 0);
    chk("byte_misaligned", data_out, 32'd0);
    op(BASE + 12, 4'd4, 1'b0, 0);
    chk("reserved_rd", data_out, 32'd0);
    op(BASE + 8, 4'd4, 1'b0, 0);
    chk("ctrl_rd", data_out, 32'd1);
    @(negedge clock);
    chk("ctrl_rd_once", data_out, 32'd0);
    op(BASE + 16, 4'd4, 1'b1, 32'h77);
    op(BASE + 24, 4'd4, 1'b1, 32'h0);
    op(BASE + 4, 4'd4, 1'b0, 0);
    chk("outside_status", data_out, 32'h0000_0002);
    op(BASE + 8, 4'd1, 1'b0, 0);
    chk("outside_ctrl", data_out, 32'd1);

    // Randomized traffic, checked each cycle against the model
    for (int i = 0; i < 4000; i++) begin
      int r;
      logic [31:0] a;
      r = $urandom_range(0, 99);
      case ($urandom_range(0, 4))
        0: w = 4'd1;
        1, 2: w = 4'd4;
        3: w = 4'(2 * $urandom_range(1, 4) - 1 + 1);
        default: w = 4'd0;
      endcase
      if (r < 8) a = $urandom;
      else if (r < 18) a = BASE + 32'($urandom_range(16, 31));
      else a = BASE + 32'($urandom_range(0, 15));
      if (r >= 60) op(a, 4'd0, 1'b0, $urandom);
      else if (a[3:2] == 2'd2 && $urandom_range(0, 3) != 0) op(a, w, 1'b1, 32'd1);
      else op(a, w, $urandom_range(0, 1) == 1, $urandom);
    end

    op(BASE + 8, 4'd4, 1'b1, 1);
    n = 0;
    while (irq !== 1'b1 && n < 20000) begin
      n++;
      @(negedge clock);
    end
    chk("final_idle_irq", {31'd0, irq}, 32'd1);

    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dm_uart_tx.md
Name: dm_uart_tx

Overview:
- Memory-mapped UART transmitter that responds on the CPU32 data-memory bus.
- Uses the same address, width, write-enable, data-in and data-out signalling as the data Memory block, with read data registered one cycle after the request.
- CPU stores push bytes into a TX FIFO; a baud-rate state machine serialises them 8N1 on the tx pin.
- Sits beside dMemory; the top level steers requests by address decode.

Parameters:
- BASE_ADDR, 32'h0001_0000, base of the 16-byte register window (bits [3:0] must be 0).
- CLKS_PER_BIT, 16, clock cycles per serial bit (minimum 2).
- FIFO_DEPTH, 8, TX FIFO entries (power of two, 2..16).

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- address  in  32  byte address from the CPU data port
- width  in  4  access width: 0 = no access, 1 = byte, 4 = word; all other values are ignored
- write_en  in  1  write strobe, qualified by width != 0
- data_in  in  32  write data
- data_out  out  32  registered read data
- tx  out  1  serial output, idle high
- irq  out  1  level interrupt = ctrl_enable & fifo_empty & !busy

Behaviour:
- Select: sel = (address[31:4] == BASE_ADDR[31:4]) && (width == 1 || width == 4).
  - Offset = address[3:2].
  - A byte access reads or writes bits [7:0] of the register; it is valid only when address[1:0] == 0, otherwise it is ignored and reads return 0.
- Register map:
  - 0x0 TXDATA: a write pushes data_in[7:0]; reads return 0.
  - 0x4 STATUS (read): bit0 full, bit1 empty, bit2 busy, bit3 overflow (sticky), bits[8:4] count. Writing 1 to bit3 clears overflow; all other bits are read-only.
  - 0x8 CTRL: bit0 enable (reset 1), read/write.
  - 0xC: reserved; reads 0, writes are ignored.
- Read timing: data_out is updated on every rising edge.
  - It takes the register value when sel && !write_en, otherwise 0 (same as Memory: 0 when idle).
  - Latency is exactly 1 cycle.
  - A write cycle returns 0 on data_out.
- FIFO push: happens on the edge where sel && write_en && offset 0.
  - If full, the byte is dropped and overflow is set on the same edge.
- FIFO pop: the shifter pops in the same cycle it leaves IDLE.
  - A push and a pop on the same edge keep count unchanged.
  - A push to a full FIFO on the same edge as a pop is accepted; no overflow.
- Pointers wrap modulo FIFO_DEPTH. count ranges 0..FIFO_DEPTH and needs log2(DEPTH)+1 bits.
- TX state machine: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: tx=1. When enable && !empty: pop into the shift register, load the baud counter with CLKS_PER_BIT-1, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles; bit index 0..7.
  - STOP: tx=1 for CLKS_PER_BIT cycles. Then return to IDLE, or go directly to START if enable && !empty, with no extra idle cycle.
  - busy = (state != IDLE).
- Clearing enable mid-frame finishes the current frame; no new frame starts while enable is 0.
- Frame length is exactly 10*CLKS_PER_BIT cycles. Back-to-back frames have no gap.
- Reset (async, any time, including mid-frame):
  - state IDLE, tx=1, FIFO empty, pointers 0, overflow 0, enable 1, data_out 0, irq 1.
  - Frame in progress is aborted.
- Write and read of the same register on one edge cannot occur (single port).
- Addresses outside the window leave all state unchanged.

Test Plan:
- Reset: assert reset low mid-frame -> tx=1 immediately (async), data_out=0. Read STATUS after release -> 32'h0000_0002 (empty). irq=1.
- Single byte: word write 32'h0000_00A5 to BASE+0, CLKS_PER_BIT=16 ->
  - tx low starts 1 cycle later;
  - bit sequence 0,1,0,1,0,0,1,0,1,1, each 16 cycles;
  - busy high for 160 cycles;
  - irq low during the frame, high after.
- Back-to-back: push 8'h55, 8'h0F in consecutive cycles -> 320 contiguous tx cycles, no idle gap. STATUS count reads 1 after the first pop, 0 after the second.
- Overflow: with enable=0, push 9 bytes into DEPTH=8 -> STATUS = full | count 8 | overflow = 32'h0000_0089.
  - Write 8 to STATUS -> overflow clears.
  - Set enable=1 -> exactly 8 frames are sent.
- Push/pop collision: FIFO full, push on the same edge the shifter pops -> no overflow, count stays 8.
- Bus compliance: byte read of BASE+5 -> 0; read of BASE+0xC -> 0; read of BASE+0x8 -> 1 on the following cycle only. Access at BASE+0x10 -> no state change.
